// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants for the ADC sequencer/averager
// Purpose: FSM state encodings, ADC sample width and default timing values
//          shared by adc_sample_avg and adc_period_tick.
// Ports:   none (package).
package adc_pkg;

   localparam int ADC_W             = 8;
   localparam int DEF_SAMPLE_PERIOD = 1000;
   localparam int DEF_TIMEOUT       = 16;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_LOW  = 2'd1;
   localparam logic [1:0] ST_WAIT_HIGH = 2'd2;

endpackage

// File: rtl/adc_period_tick.sv
// rtl/adc_period_tick.sv - free-running conversion period counter
// Purpose: counts 0..SAMPLE_PERIOD-1 while enabled and flags the last count.
// Ports:   clk, rst    - clock, synchronous active-high reset
//          enable      - count when 1; no tick is produced when 0
//          clear       - force the counter back to 0 (held off while a
//                        conversion is still in flight)
//          tick        - high for the cycle at count SAMPLE_PERIOD-1
module adc_period_tick
   import adc_pkg::*;
#(
   parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int                 CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(SAMPLE_PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/adc_sample_avg.sv
// rtl/adc_sample_avg.sv - SPI ADC conversion sequencer and 2^LOG2_N averager
// Purpose: requests a conversion every SAMPLE_PERIOD clocks, captures the
//          result on the cs_n rising edge, and emits the truncated mean of
//          every 2^LOG2_N samples with a one-cycle strobe.
// Build option: define ADC_AVG_MINMAX_EN to add per-window min/max outputs.
// Ports:   clk, rst        - clock, synchronous active-high reset
//          enable          - run sampling when 1
//          cs_n, adc_data  - chip select and shifted result from SPI master
//          start           - one-cycle conversion request to SPI master
//          avg_data        - last window mean, avg_valid strobes on update
//          busy            - FSM not idle
//          overrun         - sticky: a period tick arrived while not idle
//          timeout_err     - sticky: cs_n did not fall within TIMEOUT
//          min_data, max_data - window extremes (ADC_AVG_MINMAX_EN only)
module adc_sample_avg
   import adc_pkg::*;
#(
   parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
   parameter int LOG2_N        = 2,
   parameter int TIMEOUT       = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             cs_n,
   input  logic [ADC_W-1:0] adc_data,
   output logic             start,
   output logic [ADC_W-1:0] avg_data,
   output logic             avg_valid,
   output logic             busy,
   output logic             overrun,
`ifdef ADC_AVG_MINMAX_EN
   output logic [ADC_W-1:0] min_data,
   output logic [ADC_W-1:0] max_data,
`endif
   output logic             timeout_err
);

   // The accumulator is wide enough for 2^LOG2_N full-scale samples.
   localparam int               ACC_W    = ADC_W + LOG2_N;
   localparam int               SMP_W    = LOG2_N + 1;
   localparam int               TO_W     = $clog2(TIMEOUT + 1);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << LOG2_N) - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic             cs_prev_q, cs_prev_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
   logic [ADC_W-1:0] avg_data_q, avg_data_d;
   logic             avg_valid_q, avg_valid_d;
   logic             overrun_q, overrun_d;
   logic             timeout_err_q, timeout_err_d;
`ifdef ADC_AVG_MINMAX_EN
   logic [ADC_W-1:0] min_win_q, min_win_d, max_win_q, max_win_d;
   logic [ADC_W-1:0] min_data_q, min_data_d, max_data_q, max_data_d;
   logic [ADC_W-1:0] min_nx, max_nx;
`endif

   logic             idle;
   logic             tick;
   logic             cap_edge;
   logic [ACC_W-1:0] sum;

   assign idle     = (state_q == ST_IDLE);
   assign cap_edge = cs_n && !cs_prev_q;

   // The counter is only cleared once any in-flight conversion has finished.
   adc_period_tick #(
      .SAMPLE_PERIOD (SAMPLE_PERIOD)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .clear  (!enable && idle),
      .tick   (tick)
   );

   always_comb begin
      state_d       = state_q;
      cs_prev_d     = cs_n;
      to_cnt_d      = to_cnt_q;
      acc_d         = acc_q;
      smp_cnt_d     = smp_cnt_q;
      avg_data_d    = avg_data_q;
      avg_valid_d   = 1'b0;
      overrun_d     = overrun_q;
      timeout_err_d = timeout_err_q;
      start         = 1'b0;
      sum           = acc_q + ACC_W'(adc_data);
`ifdef ADC_AVG_MINMAX_EN
      min_win_d  = min_win_q;
      max_win_d  = max_win_q;
      min_data_d = min_data_q;
      max_data_d = max_data_q;
      min_nx     = (adc_data < min_win_q) ? adc_data : min_win_q;
      max_nx     = (adc_data > max_win_q) ? adc_data : max_win_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               start    = 1'b1;
               state_d  = ST_WAIT_LOW;
               to_cnt_d = TO_W'(1);   // counts clocks since start
            end
         end
         ST_WAIT_LOW: begin
            if (!cs_n) begin
               state_d = ST_WAIT_HIGH;
            end else if (to_cnt_q == TO_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_WAIT_HIGH: begin
            if (cap_edge) begin
               state_d = ST_IDLE;
               // A conversion finishing after enable dropped is discarded.
               if (enable) begin
                  if (smp_cnt_q == SMP_LAST) begin
                     avg_data_d  = ADC_W'(sum >> LOG2_N);
                     avg_valid_d = 1'b1;
                     acc_d       = '0;
                     smp_cnt_d   = '0;
`ifdef ADC_AVG_MINMAX_EN
                     min_data_d = min_nx;
                     max_data_d = max_nx;
                     min_win_d  = '1;
                     max_win_d  = '0;
`endif
                  end else begin
                     acc_d     = sum;
                     smp_cnt_d = smp_cnt_q + 1'b1;
`ifdef ADC_AVG_MINMAX_EN
                     min_win_d = min_nx;
                     max_win_d = max_nx;
`endif
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Ticks outside IDLE (including one coinciding with capture) are dropped.
      if (tick && !idle) begin
         overrun_d = 1'b1;
      end

      if (!enable && idle) begin
         acc_d         = '0;
         smp_cnt_d     = '0;
         overrun_d     = 1'b0;
         timeout_err_d = 1'b0;
`ifdef ADC_AVG_MINMAX_EN
         min_win_d = '1;
         max_win_d = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cs_prev_q     <= 1'b1;
         to_cnt_q      <= '0;
         acc_q         <= '0;
         smp_cnt_q     <= '0;
         avg_data_q    <= '0;
         avg_valid_q   <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
`ifdef ADC_AVG_MINMAX_EN
         min_win_q  <= '1;
         max_win_q  <= '0;
         min_data_q <= '0;
         max_data_q <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cs_prev_q     <= cs_prev_d;
         to_cnt_q      <= to_cnt_d;
         acc_q         <= acc_d;
         smp_cnt_q     <= smp_cnt_d;
         avg_data_q    <= avg_data_d;
         avg_valid_q   <= avg_valid_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
`ifdef ADC_AVG_MINMAX_EN
         min_win_q  <= min_win_d;
         max_win_q  <= max_win_d;
         min_data_q <= min_data_d;
         max_data_q <= max_data_d;
`endif
      end
   end

   assign avg_data    = avg_data_q;
   assign avg_valid   = avg_valid_q;
   assign busy        = !idle;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_err_q;
`ifdef ADC_AVG_MINMAX_EN
   assign min_data    = min_data_q;
   assign max_data    = max_data_q;
`endif

endmodule

// File: tb/tb_adc_sample_avg.sv
// tb/tb_adc_sample_avg.sv - scoreboard bench for adc_sample_avg (ADC_AVG_MINMAX_EN optional)
module tb_adc_sample_avg;

   localparam int P0 = 200, P1 = 50, P2 = 20;
   localparam int L0 = 2,   L1 = 4,  L2 = 0;

   typedef struct {
      int         due;
      logic [7:0] avg;
      logic [7:0] mn;
      logic [7:0] mx;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [2:0]      en = 3'b000;
   logic            cs_n = 1'b1;
   logic [7:0]      adc_data = 8'h00;
   logic [2:0]      start, avg_valid, busy, overrun, timeout_err;
   logic [2:0][7:0] avg_data;
`ifdef ADC_AVG_MINMAX_EN
   logic [2:0][7:0] min_data, max_data;
`endif

   int         pass_cnt = 0, total_cnt = 0, cyc = 0, ch = 0;
   int         spi_len = 20, spi_left = 0, conv_done = 0;
   bit         spi_hold = 1'b0, conv_live = 1'b0;
   logic [7:0] stim_q[$];
   int         clr_req = 0, clr_seen = 0;
   int         win_cnt = 0, win_sum = 0;
   logic [7:0] win_min = 8'hFF, win_max = 8'h00, last_avg = 8'h00;
   exp_t       exp_q[$];
   exp_t       e_mon, e_mod;
   logic [7:0] v_mod;
   bit         ok;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      adc_sample_avg #(
         .SAMPLE_PERIOD (g == 0 ? P0 : (g == 1 ? P1 : P2)),
         .LOG2_N        (g == 0 ? L0 : (g == 1 ? L1 : L2)),
         .TIMEOUT       (16)
      ) dut (
         .clk         (clk),
         .rst         (rst),
         .enable      (en[g]),
         .cs_n        (cs_n),
         .adc_data    (adc_data),
         .start       (start[g]),
         .avg_data    (avg_data[g]),
         .avg_valid   (avg_valid[g]),
         .busy        (busy[g]),
         .overrun     (overrun[g]),
`ifdef ADC_AVG_MINMAX_EN
         .min_data    (min_data[g]),
         .max_data    (max_data[g]),
`endif
         .timeout_err (timeout_err[g])
      );
   end

   function automatic int lg_of(input int c);
      case (c)
         0:       return L0;
         1:       return L1;
         default: return L2;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor first, then the SPI model, both on the falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (avg_valid[i] === 1'b1) begin
            total_cnt++;
            if (i != ch || exp_q.size() == 0) begin
               $display("FAIL unexpected_avg_valid: dut%0d avg=%02h at cycle %0d, none expected", i, avg_data[i], cyc);
            end else begin
               e_mon = exp_q.pop_front();
               ok = (cyc == e_mon.due) && (avg_data[i] === e_mon.avg);
`ifdef ADC_AVG_MINMAX_EN
               ok = ok && (min_data[i] === e_mon.mn) && (max_data[i] === e_mon.mx);
`endif
               if (ok) pass_cnt++;
               else begin
                  $display("FAIL avg_result: dut%0d avg=%02h at cycle %0d, expected avg=%02h at cycle %0d", i, avg_data[i], cyc, e_mon.avg, e_mon.due);
`ifdef ADC_AVG_MINMAX_EN
                  $display("  min=%02h max=%02h, expected min=%02h max=%02h", min_data[i], max_data[i], e_mon.mn, e_mon.mx);
`endif
               end
            end
         end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
         total_cnt++;
         e_mon = exp_q.pop_front();
         $display("FAIL avg_missing: no avg_valid by cycle %0d, expected avg=%02h at cycle %0d", cyc, e_mon.avg, e_mon.due);
      end

      if (rst || clr_req != clr_seen) begin
         clr_seen = clr_req;
         win_cnt  = 0;
         win_sum  = 0;
         win_min  = 8'hFF;
         win_max  = 8'h00;
         if (rst) conv_live = 1'b0;
      end
      if (spi_left > 0) begin
         spi_left--;
         if (spi_left == 0) begin
            v_mod = 8'h00;
            if (stim_q.size() > 0) v_mod = stim_q.pop_front();
            adc_data = v_mod;
            cs_n     = 1'b1;
            conv_done++;
            if (conv_live && en[ch] && !rst) begin
               win_sum += int'(v_mod);
               win_cnt++;
               if (v_mod < win_min) win_min = v_mod;
               if (v_mod > win_max) win_max = v_mod;
               if (win_cnt == (1 << lg_of(ch))) begin
                  e_mod.due = cyc + 1;
                  e_mod.avg = 8'(win_sum >> lg_of(ch));
                  e_mod.mn  = win_min;
                  e_mod.mx  = win_max;
                  last_avg  = e_mod.avg;
                  exp_q.push_back(e_mod);
                  win_cnt = 0;
                  win_sum = 0;
                  win_min = 8'hFF;
                  win_max = 8'h00;
               end
            end
            conv_live = 1'b0;
         end
      end else if (start[ch] === 1'b1 && !spi_hold && !rst) begin
         cs_n      = 1'b0;
         spi_left  = spi_len;
         conv_live = 1'b1;
      end
   end

   task automatic set_enable(input bit v);
      @(posedge clk); #1;
      en[ch] = v;
      if (!v) clr_req++;
   endtask

   task automatic wait_convs(input int n, input int budget);
      int base = conv_done;
      int k = 0;
      while (conv_done - base < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      total_cnt++;
      if (conv_done - base >= n) pass_cnt++;
      else $display("FAIL conv_budget: %0d of %0d conversions within %0d cycles", conv_done - base, n, budget);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_start(output int t, input int budget);
      int k = 0;
      @(negedge clk);
      while (start[ch] !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      t = cyc;
      total_cnt++;
      if (start[ch] === 1'b1) pass_cnt++;
      else $display("FAIL start_budget: no start within %0d cycles", budget);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if ({start[i], avg_valid[i], busy[i], overrun[i], timeout_err[i]} !== 5'b0) $display("FAIL reset_flags: dut%0d start/valid/busy/ovr/to=%05b, required 00000", i, {start[i], avg_valid[i], busy[i], overrun[i], timeout_err[i]});
         else pass_cnt++;
         total_cnt++;
         if (avg_data[i] !== 8'h00) $display("FAIL reset_avg: dut%0d avg_data=%02h, required 00", i, avg_data[i]);
         else pass_cnt++;
`ifdef ADC_AVG_MINMAX_EN
         total_cnt++;
         if (min_data[i] !== 8'h00 || max_data[i] !== 8'h00) $display("FAIL reset_minmax: dut%0d min=%02h max=%02h, required 00 00", i, min_data[i], max_data[i]);
         else pass_cnt++;
`endif
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_average;
      ch = 0; spi_len = 20;
      stim_q.push_back(8'h10); stim_q.push_back(8'h20); stim_q.push_back(8'h30); stim_q.push_back(8'h41);
      set_enable(1'b1);
      wait_convs(4, 4 * P0 + 250);
      total_cnt++;
      if (avg_data[0] !== 8'h28) $display("FAIL avg4_value: avg_data=%02h, required 28", avg_data[0]);
      else pass_cnt++;
      total_cnt++;
      if (overrun[0] !== 1'b0 || timeout_err[0] !== 1'b0) $display("FAIL avg4_flags: overrun=%b timeout_err=%b, required 0 0", overrun[0], timeout_err[0]);
      else pass_cnt++;
      set_enable(1'b0);
      repeat (30) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int t;
      ch = 0; spi_len = 20;
      repeat (4) stim_q.push_back(8'h50);
      stim_q.push_back(8'h70); stim_q.push_back(8'h70); stim_q.push_back(8'h7F);
      set_enable(1'b1);
      wait_convs(6, 6 * P0 + 250);
      total_cnt++;
      if (avg_data[0] !== 8'h50) $display("FAIL pre_reset_avg: avg_data=%02h, required 50", avg_data[0]);
      else pass_cnt++;
      wait_start(t, P0 + 10);
      repeat (5) @(negedge clk);
      total_cnt++;
      if (busy[0] !== 1'b1) $display("FAIL busy_in_wait_high: busy=%b, required 1", busy[0]);
      else pass_cnt++;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({start[0], avg_valid[0], busy[0], overrun[0], timeout_err[0]} !== 5'b0 || avg_data[0] !== 8'h00) $display("FAIL mid_reset_values: flags=%05b avg_data=%02h, required 00000 00", {start[0], avg_valid[0], busy[0], overrun[0], timeout_err[0]}, avg_data[0]);
      else pass_cnt++;
      repeat (4) stim_q.push_back(8'h08);
      wait_convs(5, 5 * P0 + 250);
      total_cnt++;
      if (avg_data[0] !== 8'h08) $display("FAIL post_reset_avg: avg_data=%02h, required 08", avg_data[0]);
      else pass_cnt++;
      set_enable(1'b0);
      repeat (30) @(negedge clk);
   endtask

   task automatic test_timeout;
      int t;
      ch = 0; spi_hold = 1'b1;
      set_enable(1'b1);
      wait_start(t, P0 + 10);
      while (cyc < t + 15) @(negedge clk);
      total_cnt++;
      if (timeout_err[0] !== 1'b0 || busy[0] !== 1'b1) $display("FAIL timeout_early: at start+15 timeout_err=%b busy=%b, required 0 1", timeout_err[0], busy[0]);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (timeout_err[0] !== 1'b1 || busy[0] !== 1'b0) $display("FAIL timeout_edge: at start+16 timeout_err=%b busy=%b, required 1 0", timeout_err[0], busy[0]);
      else pass_cnt++;
      spi_hold = 1'b0;
      set_enable(1'b0);
      repeat (3) @(negedge clk);
      total_cnt++;
      if (timeout_err[0] !== 1'b0) $display("FAIL timeout_clear: timeout_err=%b after enable low, required 0", timeout_err[0]);
      else pass_cnt++;
   endtask

   task automatic test_overrun;
      int t0, t1;
      ch = 0; spi_len = 300;
      set_enable(1'b1);
      wait_start(t0, P0 + 10);
      wait_start(t1, 3 * P0);
      total_cnt++;
      if (t1 - t0 !== 400) $display("FAIL overrun_spacing: start spacing=%0d, required 400", t1 - t0);
      else pass_cnt++;
      total_cnt++;
      if (overrun[0] !== 1'b1) $display("FAIL overrun_set: overrun=%b, required 1", overrun[0]);
      else pass_cnt++;
      set_enable(1'b0);
      repeat (320) @(negedge clk);
      total_cnt++;
      if (overrun[0] !== 1'b0 || busy[0] !== 1'b0) $display("FAIL overrun_clear: overrun=%b busy=%b, required 0 0", overrun[0], busy[0]);
      else pass_cnt++;
      spi_len = 20;
   endtask

   task automatic test_log2n4;
      ch = 1; spi_len = 10;
      repeat (16) stim_q.push_back(8'hFF);
      set_enable(1'b1);
      wait_convs(16, 16 * P1 + 150);
      total_cnt++;
      if (avg_data[1] !== 8'hFF) $display("FAIL log2n4_full_scale: avg_data=%02h, required FF", avg_data[1]);
      else pass_cnt++;
      set_enable(1'b0);
      repeat (20) @(negedge clk);
   endtask

   task automatic test_log2n0_and_discard;
      int t;
      logic [7:0] r;
      ch = 2; spi_len = 8;
      r = 8'($urandom_range(1, 254));
      stim_q.push_back(8'hFF); stim_q.push_back(8'h00); stim_q.push_back(8'($urandom_range(0, 255))); stim_q.push_back(r);
      set_enable(1'b1);
      wait_convs(4, 4 * P2 + 60);
      total_cnt++;
      if (avg_data[2] !== r) $display("FAIL log2n0_passthrough: avg_data=%02h, required %02h", avg_data[2], r);
      else pass_cnt++;
      stim_q.push_back(8'hA5);
      wait_start(t, P2 + 10);
      repeat (4) @(negedge clk);
      set_enable(1'b0);
      repeat (12) @(negedge clk);
      total_cnt++;
      if (avg_data[2] !== last_avg || busy[2] !== 1'b0) $display("FAIL discard_hold: avg_data=%02h busy=%b, required %02h 0", avg_data[2], busy[2], last_avg);
      else pass_cnt++;
   endtask

   task automatic test_minmax;
      ch = 0; spi_len = 20;
      stim_q.push_back(8'h10); stim_q.push_back(8'h80); stim_q.push_back(8'h05); stim_q.push_back(8'h40);
      set_enable(1'b1);
      wait_convs(4, 4 * P0 + 250);
      total_cnt++;
      if (avg_data[0] !== 8'h35) $display("FAIL minmax_avg: avg_data=%02h, required 35", avg_data[0]);
      else pass_cnt++;
`ifdef ADC_AVG_MINMAX_EN
      total_cnt++;
      if (min_data[0] !== 8'h05 || max_data[0] !== 8'h80) $display("FAIL minmax_values: min=%02h max=%02h, required 05 80", min_data[0], max_data[0]);
      else pass_cnt++;
`endif
      set_enable(1'b0);
      repeat (30) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_average();
      test_reset_mid();
      test_timeout();
      test_overrun();
      test_log2n4();
      test_log2n0_and_discard();
      test_minmax();
      repeat (5) @(negedge clk);
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d averages never produced", exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
